biphasemark_rx_ctrl: RTL

Supervisory controller for the `biphasemark_decode` receive path. It gates the decoder reset from the optical-link valid signal and checks the decoder's per-subframe output: payload bit count, channel alternation and frame-counter progression. It declares lock after a run of consistent subframes and, while locked, assembles payload bits into samples for downstream audio logic. On any inconsistency or stall it drops lock, re-resets the decoder and re-acquires.

---
 rtl/biphasemark_rx_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/biphasemark_rx_ctrl.sv
// Supervisory controller for the biphasemark_decode receive path: gates the decoder
// reset, validates each decoded subframe, tracks lock and assembles payload samples.
module biphasemark_rx_ctrl #(
    parameter int P_BITS         = 28,
    parameter int RST_CYCLES     = 4,
    parameter int LOCK_SUBFRAMES = 4,
    parameter int TIMEOUT        = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vin,
    input  logic              dec_dout,
    input  logic              dec_vout,
    input  logic [7:0]        dec_frame_counter,
    input  logic              dec_channel,
    output logic              dec_rst,
    output logic              locked,
    output logic [P_BITS-1:0] sample,
    output logic              sample_channel,
    output logic              sample_valid,
    output logic              block_start,
    output logic [7:0]        err_count
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int GW = $clog2(LOCK_SUBFRAMES + 1);

    typedef enum logic [1:0] {IDLE, RESET, ACQUIRE, LOCKED} state_t;
    state_t state;

    logic [5:0]        bitcnt;
    logic [P_BITS-1:0] shreg;
    logic              in_sub;
    logic              cap_ch;
    logic [7:0]        cap_fc;
    logic              ref_vld;
    logic              ref_ch;
    logic [7:0]        ref_fc;
    logic [IW-1:0]     idle_cnt;
    logic [RW-1:0]     rst_cnt;
    logic [GW-1:0]     good_cnt;

    logic       sub_end;
    logic       good;
    logic       stall;
    logic [7:0] fc_next;
    logic [7:0] err_inc;

    always_comb begin
        sub_end = in_sub && !dec_vout;
        fc_next = (ref_fc == 8'd191) ? 8'd0 : ref_fc + 8'd1;
        good    = (bitcnt == 6'(P_BITS)) &&
                  (!ref_vld || ((cap_ch != ref_ch) &&
                                (cap_ch ? (cap_fc == ref_fc) : (cap_fc == fc_next))));
        stall   = !dec_vout && (idle_cnt == IW'(TIMEOUT - 1));
        err_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            dec_rst        <= 1'b1;
            locked         <= 1'b0;
            sample         <= '0;
            sample_channel <= 1'b0;
            sample_valid   <= 1'b0;
            block_start    <= 1'b0;
            err_count      <= 8'd0;
            bitcnt         <= '0;
            shreg          <= '0;
            in_sub         <= 1'b0;
            cap_ch         <= 1'b0;
            cap_fc         <= 8'd0;
            ref_vld        <= 1'b0;
            ref_ch         <= 1'b0;
            ref_fc         <= 8'd0;
            idle_cnt       <= '0;
            rst_cnt        <= '0;
            good_cnt       <= '0;
        end else begin
            sample_valid <= 1'b0;
            block_start  <= 1'b0;

            // Subframe accumulation; overridden below while the decoder is held in reset.
            if (dec_vout) begin
                bitcnt   <= (bitcnt == 6'd63) ? bitcnt : bitcnt + 6'd1;
                shreg    <= {shreg[P_BITS-2:0], dec_dout};
                cap_ch   <= dec_channel;
                cap_fc   <= dec_frame_counter;
                in_sub   <= 1'b1;
                idle_cnt <= '0;
            end else begin
                if (idle_cnt != IW'(TIMEOUT))
                    idle_cnt <= idle_cnt + 1'b1;
                if (sub_end) begin
                    in_sub <= 1'b0;
                    bitcnt <= '0;
                end
            end

            case (state)
                IDLE: begin
                    dec_rst <= 1'b1;
                    locked  <= 1'b0;
                    if (vin) begin
                        state   <= RESET;
                        rst_cnt <= '0;
                    end
                end
                RESET: begin
                    if (!vin) begin
                        state <= IDLE;
                    end else if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        state   <= ACQUIRE;
                        dec_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (!vin) begin
                        state   <= IDLE;
                        dec_rst <= 1'b1;
                    end else if (sub_end && good) begin
                        ref_vld  <= 1'b1;
                        ref_ch   <= cap_ch;
                        ref_fc   <= cap_fc;
                        good_cnt <= good_cnt + 1'b1;
                        if (good_cnt == GW'(LOCK_SUBFRAMES - 1)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else if (sub_end || stall) begin
                        state   <= RESET;
                        rst_cnt <= '0;
                        dec_rst <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!vin) begin
                        state     <= IDLE;
                        dec_rst   <= 1'b1;
                        locked    <= 1'b0;
                        err_count <= err_inc;
                    end else if (sub_end && good) begin
                        ref_ch         <= cap_ch;
                        ref_fc         <= cap_fc;
                        sample_valid   <= 1'b1;
                        sample         <= shreg;
                        sample_channel <= cap_ch;
                        block_start    <= (cap_fc == 8'd0) && !cap_ch;
                    end else if (sub_end || stall) begin
                        state     <= RESET;
                        rst_cnt   <= '0;
                        dec_rst   <= 1'b1;
                        locked    <= 1'b0;
                        err_count <= err_inc;
                    end
                end
                default: state <= IDLE;
            endcase

            if (state == IDLE || state == RESET) begin
                bitcnt   <= '0;
                shreg    <= '0;
                in_sub   <= 1'b0;
                idle_cnt <= '0;
                good_cnt <= '0;
                ref_vld  <= 1'b0;
            end
        end
    end

endmodule
